// File: rtl/vend_pkg.sv
// Shared types and helpers for the vend_ctrl credit controller: FSM state
// encoding, coin codes and the coin-code to unit-value mapping.
package vend_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      VEND   = 2'd2,
      CHANGE = 2'd3
   } vend_state_e;

   localparam logic [1:0] COIN_CODE0 = 2'd0;
   localparam logic [1:0] COIN_CODE1 = 2'd1;
   localparam logic [1:0] COIN_CODE2 = 2'd2;
   localparam logic [1:0] COIN_CODE3 = 2'd3;

   // Values are passed in so each instance can use its own coin parameters.
   function automatic int unsigned coin_value(input logic [1:0] sel,
                                              input int unsigned c0,
                                              input int unsigned c1,
                                              input int unsigned c2,
                                              input int unsigned c3);
      int unsigned v;
      case (sel)
         COIN_CODE0: v = c0;
         COIN_CODE1: v = c1;
         COIN_CODE2: v = c2;
         default:    v = c3;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/vend_ctrl_if.sv
// Coin acceptor / dispenser signal bundle for vend_ctrl. The controller sits
// on the slave modport, the front end and dispenser drivers on master.
interface vend_ctrl_if #(
   parameter int CREDIT_W = 8
);
   logic                coin_valid;
   logic [1:0]          coin_sel;
   logic                buy;
   logic                cancel;
   logic                change_ready;
   logic [CREDIT_W-1:0] credit;
   logic                vend;
   logic                deny;
   logic                coin_reject;
   logic                change_valid;
   logic [CREDIT_W-1:0] change_amt;
   logic                busy;

   modport master (
      output coin_valid, coin_sel, buy, cancel, change_ready,
      input  credit, vend, deny, coin_reject, change_valid, change_amt, busy
   );

   modport slave (
      input  coin_valid, coin_sel, buy, cancel, change_ready,
      output credit, vend, deny, coin_reject, change_valid, change_amt, busy
   );
endinterface

// File: rtl/vend_coin_value.sv
// Combinational coin-code to unit-value decoder.
module vend_coin_value
   import vend_pkg::*;
#(
   parameter int          CREDIT_W = 8,
   parameter int unsigned COIN0    = 1,
   parameter int unsigned COIN1    = 2,
   parameter int unsigned COIN2    = 5,
   parameter int unsigned COIN3    = 10
) (
   input  logic [1:0]          sel_i,
   output logic [CREDIT_W-1:0] value_o
);
   assign value_o = CREDIT_W'(coin_value(sel_i, COIN0, COIN1, COIN2, COIN3));
endmodule

// File: rtl/vend_ctrl.sv
// Vending credit controller: coin accumulation, buy/vend, cancel and change
// return. Define VEND_CTRL_AUTOVEND_EN to vend as soon as credit >= PRICE.
//
// state  | meaning
// IDLE   | no credit held
// ACCUM  | credit in 1..MAX_CREDIT, waiting for coins / buy / cancel
// VEND   | one-cycle product release, credit cleared
// CHANGE | change_amt offered to the dispenser until accepted
module vend_ctrl
   import vend_pkg::*;
#(
   parameter int          CREDIT_W   = 8,
   parameter int unsigned PRICE      = 15,
   parameter int unsigned MAX_CREDIT = 30,
   parameter int unsigned COIN0      = 1,
   parameter int unsigned COIN1      = 2,
   parameter int unsigned COIN2      = 5,
   parameter int unsigned COIN3      = 10
) (
   input logic        clock,
   input logic        reset,
   vend_ctrl_if.slave bus
);
   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W:0]   MAX_C   = (CREDIT_W+1)'(MAX_CREDIT);

   vend_state_e         state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [CREDIT_W-1:0] change_q, change_d;
   logic                deny_q, deny_d;
   logic                reject_q, reject_d;
   logic                vend_q, busy_q, change_valid_q;

   logic [CREDIT_W-1:0] coin_val;
   logic [CREDIT_W:0]   coin_sum;
   logic                cancel_go, vend_go, buy_deny;

   vend_coin_value #(
      .CREDIT_W (CREDIT_W),
      .COIN0    (COIN0),
      .COIN1    (COIN1),
      .COIN2    (COIN2),
      .COIN3    (COIN3)
   ) u_coin_value (
      .sel_i   (bus.coin_sel),
      .value_o (coin_val)
   );

   // One extra bit so the overflow compare can never see a wrapped sum.
   assign coin_sum = {1'b0, credit_q} + {1'b0, coin_val};

   always_comb begin
      state_d   = state_q;
      credit_d  = credit_q;
      change_d  = change_q;
      deny_d    = 1'b0;
      reject_d  = 1'b0;
      cancel_go = bus.cancel && (state_q == ACCUM);
`ifdef VEND_CTRL_AUTOVEND_EN
      vend_go   = (state_q == ACCUM) && (credit_q >= PRICE_C);
      buy_deny  = 1'b0;
`else
      vend_go   = bus.buy && (state_q == ACCUM) && (credit_q >= PRICE_C);
      buy_deny  = bus.buy && !vend_go;
`endif
      case (state_q)
         IDLE, ACCUM: begin
            if (cancel_go) begin
               change_d = credit_q;
               credit_d = '0;
               state_d  = CHANGE;
               reject_d = bus.coin_valid;
            end else if (vend_go) begin
               change_d = credit_q - PRICE_C;
               credit_d = '0;
               state_d  = VEND;
               reject_d = bus.coin_valid;
            end else if (buy_deny) begin
               deny_d   = 1'b1;
               reject_d = bus.coin_valid;
            end else if (bus.coin_valid) begin
               if (coin_sum <= MAX_C) begin
                  credit_d = coin_sum[CREDIT_W-1:0];
                  state_d  = ACCUM;
               end else begin
                  reject_d = 1'b1;
               end
            end
         end
         VEND: begin
            reject_d = bus.coin_valid;
            state_d  = (change_q != '0) ? CHANGE : IDLE;
         end
         CHANGE: begin
            reject_d = bus.coin_valid;
            if (bus.change_ready) begin
               change_d = '0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= IDLE;
         credit_q       <= '0;
         change_q       <= '0;
         deny_q         <= 1'b0;
         reject_q       <= 1'b0;
         vend_q         <= 1'b0;
         busy_q         <= 1'b0;
         change_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         credit_q       <= credit_d;
         change_q       <= change_d;
         deny_q         <= deny_d;
         reject_q       <= reject_d;
         vend_q         <= (state_d == VEND);
         busy_q         <= (state_d == VEND) || (state_d == CHANGE);
         change_valid_q <= (state_d == CHANGE);
      end
   end

   assign bus.credit       = credit_q;
   assign bus.vend         = vend_q;
   assign bus.deny         = deny_q;
   assign bus.coin_reject  = reject_q;
   assign bus.change_valid = change_valid_q;
   assign bus.change_amt   = change_q;
   assign bus.busy         = busy_q;
endmodule

// File: tb/tb_vend_ctrl.sv
// Directed table-driven bench for vend_ctrl with default parameters
// (PRICE 15, MAX_CREDIT 30, coins 1/2/5/10).
module tb_vend_ctrl;
   localparam int CREDIT_W = 8;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clock = ~clock;

   vend_ctrl_if #(.CREDIT_W(CREDIT_W)) bus ();

   vend_ctrl #(
      .CREDIT_W   (CREDIT_W),
      .PRICE      (15),
      .MAX_CREDIT (30),
      .COIN0      (1),
      .COIN1      (2),
      .COIN2      (5),
      .COIN3      (10)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic       cv;
      logic [1:0] sel;
      logic       buy;
      logic       cancel;
      logic       rdy;
      int         credit;
      logic       vend;
      logic       deny;
      logic       rej;
      logic       chv;
      int         camt;
      logic       busy;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input vec_t v);
      check({tag, " credit"}, int'(bus.credit), v.credit);
      check({tag, " vend"}, int'(bus.vend), int'(v.vend));
      check({tag, " deny"}, int'(bus.deny), int'(v.deny));
      check({tag, " coin_reject"}, int'(bus.coin_reject), int'(v.rej));
      check({tag, " change_valid"}, int'(bus.change_valid), int'(v.chv));
      check({tag, " change_amt"}, int'(bus.change_amt), v.camt);
      check({tag, " busy"}, int'(bus.busy), int'(v.busy));
   endtask

   task automatic drive(input vec_t v);
      bus.coin_valid   = v.cv;
      bus.coin_sel     = v.sel;
      bus.buy          = v.buy;
      bus.cancel       = v.cancel;
      bus.change_ready = v.rdy;
   endtask

   // cv sel buy cancel rdy | credit vend deny rej chv camt busy
   function automatic vec_t mk(input logic cv, input logic [1:0] sel,
                               input logic buy, input logic cancel,
                               input logic rdy, input int credit,
                               input logic vend, input logic deny,
                               input logic rej, input logic chv,
                               input int camt, input logic busy);
      vec_t v;
      v = '{cv, sel, buy, cancel, rdy, credit, vend, deny, rej, chv, camt, busy};
      return v;
   endfunction

   localparam logic [1:0] C1 = 2'd0, C2 = 2'd1, C5 = 2'd2, C10 = 2'd3;

   initial begin
      vec_t idle_v;
      idle_v = mk(0, C1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(idle_v);

`ifndef VEND_CTRL_AUTOVEND_EN
      // coins 10,5 then buy: exact price, no change
      vecs.push_back(mk(1, C10, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, C5,  0, 0, 0, 15, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, C1,  1, 0, 0,  0, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, C1,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
      // coins 10,10, buy, dispenser stalls three cycles
      vecs.push_back(mk(1, C10, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, C10, 0, 0, 0, 20, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, C1,  1, 0, 0,  0, 1, 0, 0, 0, 5, 1));
      vecs.push_back(mk(0, C1,  0, 0, 0,  0, 0, 0, 0, 1, 5, 1));
      vecs.push_back(mk(0, C1,  0, 0, 0,  0, 0, 0, 0, 1, 5, 1));
      vecs.push_back(mk(0, C1,  0, 0, 0,  0, 0, 0, 0, 1, 5, 1));
      vecs.push_back(mk(0, C1,  0, 0, 1,  0, 0, 0, 0, 0, 0, 0));
      // coin 5, short buy denied, then cancel refunds
      vecs.push_back(mk(1, C5,  0, 0, 0,  5, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, C1,  1, 0, 0,  5, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, C1,  0, 1, 0,  0, 0, 0, 0, 1, 5, 1));
      vecs.push_back(mk(0, C1,  0, 0, 1,  0, 0, 0, 0, 0, 0, 0));
      // fill to ceiling, overflow coin, coin+cancel
      vecs.push_back(mk(1, C10, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, C10, 0, 0, 0, 20, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, C10, 0, 0, 0, 30, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, C1,  0, 0, 0, 30, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(1, C1,  0, 1, 0,  0, 0, 0, 1, 1, 30, 1));
      vecs.push_back(mk(0, C1,  0, 0, 1,  0, 0, 0, 0, 0, 0, 0));
      // coin during VEND rejected, buy during CHANGE ignored
      vecs.push_back(mk(1, C10, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, C10, 0, 0, 0, 20, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, C1,  1, 0, 0,  0, 1, 0, 0, 0, 5, 1));
      vecs.push_back(mk(1, C1,  0, 0, 0,  0, 0, 0, 1, 1, 5, 1));
      vecs.push_back(mk(0, C1,  1, 0, 0,  0, 0, 0, 0, 1, 5, 1));
      vecs.push_back(mk(0, C1,  0, 0, 1,  0, 0, 0, 0, 0, 0, 0));
      // exact ceiling accepted at 29+1, then 30+2 rejected, buy gives 15 change
      vecs.push_back(mk(1, C10, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, C10, 0, 0, 0, 20, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, C5,  0, 0, 0, 25, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, C2,  0, 0, 0, 27, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, C2,  0, 0, 0, 29, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, C1,  0, 0, 0, 30, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, C2,  0, 0, 0, 30, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, C1,  1, 0, 1,  0, 1, 0, 0, 0, 15, 1));
      vecs.push_back(mk(0, C1,  0, 0, 1,  0, 0, 0, 0, 1, 15, 1));
      vecs.push_back(mk(0, C1,  0, 0, 1,  0, 0, 0, 0, 0, 0, 0));
      // build a pending change for the reset-in-CHANGE sequence
      vecs.push_back(mk(1, C10, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, C10, 0, 0, 0, 20, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, C1,  1, 0, 0,  0, 1, 0, 0, 0, 5, 1));
      vecs.push_back(mk(0, C1,  0, 0, 0,  0, 0, 0, 0, 1, 5, 1));
`else
      // credit reaching price vends without buy; buy below price not denied
      vecs.push_back(mk(1, C5,  0, 0, 0,  5, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, C1,  1, 0, 0,  5, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, C10, 0, 0, 0, 15, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, C1,  0, 0, 0,  0, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, C1,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, C10, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, C10, 0, 0, 0, 20, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, C1,  0, 0, 0,  0, 1, 0, 0, 0, 5, 1));
      vecs.push_back(mk(0, C1,  0, 0, 0,  0, 0, 0, 0, 1, 5, 1));
`endif

      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      check_outs("reset", idle_v);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         @(posedge clock);
         #1;
         check_outs($sformatf("vec%0d", i), vecs[i]);
      end

      // reset while change is pending discards it
      drive(idle_v);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      check_outs("reset_in_change", idle_v);
      @(posedge clock);
      #1;
      check_outs("after_reset", idle_v);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/vend_ctrl.md
# vend_ctrl

Parametrised vending-machine credit controller: it accumulates multi-denomination coin credit, vends on a buy request once credit reaches a configurable price, and returns change or refunds through a valid/ready dispenser handshake. It sits between the coin-acceptor front end and the product/change dispenser drivers. It replaces the fixed single-coin 8-state counter with a credit register, an explicit price, overflow rejection, cancel and change return.

## Interface
- CREDIT_W, 8: width of credit, price and change values (units).
- PRICE, 15: item price in units; 1 ≤ PRICE ≤ MAX_CREDIT.
- MAX_CREDIT, 30: credit ceiling; must be < 2**CREDIT_W.
- COIN0..COIN3, 1/2/5/10: unit value of each coin code.
- Clocking and reset: reset is synchronous and active-high; the clock is `clock`.
- clock  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- coin_valid  in  1  one-cycle pulse, a coin has been inserted.
- coin_sel  in  2  coin code, sampled with coin_valid.
- buy  in  1  one-cycle purchase request.
- cancel  in  1  one-cycle refund request.
- change_ready  in  1  dispenser accepts change_amt.
- credit  out  CREDIT_W  current credit.
- vend  out  1  one-cycle product release pulse.
- deny  out  1  one-cycle pulse: buy with credit < PRICE.
- coin_reject  out  1  one-cycle pulse: coin refused, to be returned by the acceptor.
- change_valid  out  1  change_amt is valid.
- change_amt  out  CREDIT_W  amount to dispense.
- busy  out  1  high in VEND and CHANGE.

## Operation
- States:
  - IDLE: credit = 0.
  - ACCUM: 0 < credit < MAX_CREDIT, or credit = MAX_CREDIT.
  - VEND: one cycle.
  - CHANGE: held until the handshake completes.
- Coin handling in IDLE/ACCUM:
  - If credit + COINn ≤ MAX_CREDIT, credit += COINn and the state becomes ACCUM.
  - Otherwise coin_reject pulses and credit is unchanged.
  - The sum is computed at CREDIT_W+1 bits, so it never wraps.
- Coin in VEND/CHANGE: always rejected (coin_reject pulse); credit unchanged.
- buy in ACCUM:
  - If credit ≥ PRICE: go to VEND and load change_amt = credit − PRICE.
  - Else: deny pulses and the state is unchanged.
  - buy in IDLE: deny pulses.
- VEND:
  - vend = 1 and credit = 0.
  - Next state is CHANGE if change_amt ≠ 0, otherwise IDLE.
- cancel in ACCUM: change_amt = credit, credit = 0, go to CHANGE with no vend. cancel in IDLE is ignored.
- CHANGE:
  - change_valid = 1; change_amt is held stable until change_valid && change_ready.
  - On that cycle the block returns to IDLE and clears change_amt.
- Simultaneous events in one cycle:
  - Priority is cancel > buy > coin.
  - A coin that loses arbitration is rejected.
- buy or cancel in VEND/CHANGE is ignored; deny does not pulse.
- Dropping change_ready does not abort CHANGE.

## Timing
- All outputs are registered.
- Reset values: credit 0, vend 0, deny 0, coin_reject 0, change_valid 0, change_amt 0, busy 0; state IDLE.
- coin_valid at cycle N → credit or coin_reject updated at N+1.
- buy at N with sufficient credit → vend high at N+1 only; change_valid high from N+2 when change ≠ 0.
- cancel at N → credit 0 and change_valid high at N+1.
- Handshake completes at cycle M → change_valid is 0 at M+1. Throughput is one transaction per handshake.
- reset asserted in any state, including mid-CHANGE → every output is at its reset value the next cycle. A pending change is discarded.

## Configuration
- VEND_CTRL_AUTOVEND_EN defined:
  - ACCUM enters VEND automatically on the cycle after credit ≥ PRICE; buy is ignored and deny never pulses.
  - cancel in that same cycle still wins.
- Undefined: an explicit buy is required, as described in Operation.

## Structure
- Shared package vend_pkg holds:
  - the state enum (IDLE, ACCUM, VEND, CHANGE);
  - the coin-code constants;
  - the function coin_value(sel), which maps codes to parameters.
- Sub-module vend_coin_value: a combinational coin-code to unit-value decoder, reused by the acceptor test model.
- The top level holds the FSM, the credit register and the change register.

## Test plan
Defaults apply: PRICE=15, MAX_CREDIT=30, coins 1/2/5/10.
1. Reset → every output is at its reset value.
2. Coins 10, 5, then buy → credit 15, then vend pulse, credit 0, no change_valid, back to IDLE.
3. Coins 10, 10, buy, with change_ready low for 3 cycles → change_valid with change_amt=5 held 3 cycles, clears the cycle after ready.
4. Coin 5, then buy → deny pulse, credit stays 5. Then cancel → change_amt=5, credit 0.
5. Coins 10, 10, 10, then 1 → credit 30, coin_reject on the 4th coin. Same-cycle coin+cancel → refund 30 and the coin is rejected.
6. Reset asserted during CHANGE → change_valid=0 and credit=0 next cycle. With AUTOVEND_EN, coins 10, 5 → vend without buy.
